// File: rtl/easyaxi_ost_alloc_if.sv
// Allocation and response-retire signal bundle for easyaxi_ost_alloc.
// The slave modport is the allocator; the master modport is the AXI-side logic driving it.
interface easyaxi_ost_alloc_if #(
    parameter int OST_DEPTH = 16,
    parameter int ID_WIDTH  = 4,
    parameter int LEN_WIDTH = 8
);
    localparam int PTR_W = $clog2(OST_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                 alloc_valid;
    logic                 alloc_ready;
    logic [ID_WIDTH-1:0]  alloc_id;
    logic [LEN_WIDTH-1:0] alloc_len;
    logic [PTR_W-1:0]     alloc_ptr;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [PTR_W-1:0]     resp_ptr;
    logic                 resp_last;
    logic [ID_WIDTH-1:0]  slot_id;

    logic [CNT_W-1:0]     ost_cnt;
    logic                 ost_full;
    logic                 ost_empty;
    logic                 err_free;
    logic                 err_len;

    modport slave (
        input  alloc_valid, alloc_id, alloc_len,
        input  resp_valid, resp_ready, resp_ptr, resp_last,
        output alloc_ready, alloc_ptr, slot_id,
        output ost_cnt, ost_full, ost_empty, err_free, err_len
    );

    modport master (
        output alloc_valid, alloc_id, alloc_len,
        output resp_valid, resp_ready, resp_ptr, resp_last,
        input  alloc_ready, alloc_ptr, slot_id,
        input  ost_cnt, ost_full, ost_empty, err_free, err_len
    );
endinterface

// File: rtl/easyaxi_ost_alloc.sv
// Outstanding-transaction slot allocator: hands out the lowest free slot, retires on last beat.
// Define EASYAXI_OST_ALLOC_LEN_CHK_EN to add per-slot burst length / beat count checking.
module easyaxi_ost_alloc #(
    parameter int OST_DEPTH = 16,
    parameter int ID_WIDTH  = 4,
    parameter int LEN_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    easyaxi_ost_alloc_if.slave bus
);
    localparam int PTR_W = $clog2(OST_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [OST_DEPTH-1:0] valid_reg;
    logic [OST_DEPTH-1:0] valid_next;
    logic [OST_DEPTH-1:0] alloc_sel;
    logic [OST_DEPTH-1:0] free_sel;
    logic [ID_WIDTH-1:0]  id_reg [OST_DEPTH];
    logic [CNT_W-1:0]     cnt_reg;
    logic [CNT_W-1:0]     cnt_next;
    logic                 err_free_reg;

    logic                 full;
    logic [PTR_W-1:0]     free_ptr;
    logic                 alloc_fire;
    logic                 resp_fire;
    logic                 resp_hit;
    logic                 free_fire;

    assign full       = (cnt_reg == CNT_W'(OST_DEPTH));
    assign alloc_fire = bus.alloc_valid & ~full;
    assign resp_fire  = bus.resp_valid & bus.resp_ready;
    assign resp_hit   = resp_fire & valid_reg[bus.resp_ptr];
    assign free_fire  = resp_hit & bus.resp_last;

    // Scan downward so the lowest free index wins; no free slot leaves the pointer at 0.
    always_comb begin
        free_ptr = '0;
        for (int i = OST_DEPTH - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                free_ptr = PTR_W'(i);
            end
        end
    end

    // The allocated slot is free and the retired slot is valid, so the two never collide.
    for (genvar gi = 0; gi < OST_DEPTH; gi++) begin : g_slot
        assign alloc_sel[gi]  = alloc_fire && (free_ptr == PTR_W'(gi));
        assign free_sel[gi]   = free_fire && (bus.resp_ptr == PTR_W'(gi));
        assign valid_next[gi] = alloc_sel[gi] | (valid_reg[gi] & ~free_sel[gi]);
    end

    always_comb begin
        cnt_next = cnt_reg;
        case ({alloc_fire, free_fire})
            2'b10:   cnt_next = cnt_reg + CNT_W'(1);
            2'b01:   cnt_next = cnt_reg - CNT_W'(1);
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg    <= '0;
            cnt_reg      <= '0;
            err_free_reg <= 1'b0;
            for (int i = 0; i < OST_DEPTH; i++) begin
                id_reg[i] <= '0;
            end
        end else begin
            valid_reg <= valid_next;
            cnt_reg   <= cnt_next;
            if (resp_fire && !valid_reg[bus.resp_ptr]) begin
                err_free_reg <= 1'b1;
            end
            if (alloc_fire) begin
                id_reg[free_ptr] <= bus.alloc_id;
            end
        end
    end

`ifdef EASYAXI_OST_ALLOC_LEN_CHK_EN
    logic [LEN_WIDTH-1:0] len_reg  [OST_DEPTH];
    logic [LEN_WIDTH:0]   beat_reg [OST_DEPTH];
    logic                 err_len_reg;
    logic [LEN_WIDTH:0]   beat_cur;
    logic [LEN_WIDTH:0]   len_cur;
    logic                 len_bad;

    // beat_reg counts beats already seen, so the last beat must arrive with it equal to len.
    assign beat_cur = beat_reg[bus.resp_ptr];
    assign len_cur  = {1'b0, len_reg[bus.resp_ptr]};
    assign len_bad  = resp_hit & (bus.resp_last ? (beat_cur != len_cur) : (beat_cur == len_cur));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_len_reg <= 1'b0;
            for (int i = 0; i < OST_DEPTH; i++) begin
                len_reg[i]  <= '0;
                beat_reg[i] <= '0;
            end
        end else begin
            if (len_bad) begin
                err_len_reg <= 1'b1;
            end
            if (alloc_fire) begin
                len_reg[free_ptr]  <= bus.alloc_len;
                beat_reg[free_ptr] <= '0;
            end
            if (resp_hit) begin
                beat_reg[bus.resp_ptr] <= beat_cur + 1'b1;
            end
        end
    end

    assign bus.err_len = err_len_reg;
`else
    logic unused_len;
    assign unused_len  = ^bus.alloc_len;
    assign bus.err_len = 1'b0;
`endif

    assign bus.alloc_ready = ~full;
    assign bus.alloc_ptr   = free_ptr;
    assign bus.slot_id     = id_reg[bus.resp_ptr];
    assign bus.ost_cnt     = cnt_reg;
    assign bus.ost_full    = full;
    assign bus.ost_empty   = (cnt_reg == '0);
    assign bus.err_free    = err_free_reg;
endmodule

// File: tb/tb_easyaxi_ost_alloc.sv
// Testbench for easyaxi_ost_alloc: directed scenarios plus random traffic against a slot-table model.
module tb_easyaxi_ost_alloc;
    localparam int DEPTH = 16;
    localparam int IDW   = 4;
    localparam int LENW  = 8;
    localparam int PW    = $clog2(DEPTH);

`ifdef EASYAXI_OST_ALLOC_LEN_CHK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    easyaxi_ost_alloc_if #(.OST_DEPTH(DEPTH), .ID_WIDTH(IDW), .LEN_WIDTH(LENW)) bus ();

    easyaxi_ost_alloc #(.OST_DEPTH(DEPTH), .ID_WIDTH(IDW), .LEN_WIDTH(LENW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference model: a table of slots, occupancy derived by counting.
    bit m_occ  [DEPTH];
    int m_id   [DEPTH];
    int m_len  [DEPTH];
    int m_beat [DEPTH];
    bit m_err_free;
    bit m_err_len;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += m_occ[i];
        return n;
    endfunction

    function automatic int m_first_free();
        for (int i = 0; i < DEPTH; i++) if (!m_occ[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_occ[i] = 0; m_id[i] = 0; m_len[i] = 0; m_beat[i] = 0;
        end
        m_err_free = 0;
        m_err_len  = 0;
    endtask

    task automatic check_outputs(input string pfx);
        int c = m_cnt();
        check_eq({pfx, "_ready"}, bus.alloc_ready, (c < DEPTH));
        check_eq({pfx, "_aptr"},  bus.alloc_ptr, m_first_free());
        check_eq({pfx, "_cnt"},   bus.ost_cnt, c);
        check_eq({pfx, "_full"},  bus.ost_full, (c == DEPTH));
        check_eq({pfx, "_empty"}, bus.ost_empty, (c == 0));
        check_eq({pfx, "_sid"},   bus.slot_id, m_id[bus.resp_ptr]);
        check_eq({pfx, "_efree"}, bus.err_free, m_err_free);
        check_eq({pfx, "_elen"},  bus.err_len, LEN_CHK ? m_err_len : 1'b0);
    endtask

    task automatic idle_inputs();
        bus.alloc_valid = 0; bus.alloc_id = '0; bus.alloc_len = '0;
        bus.resp_valid = 0; bus.resp_ready = 0; bus.resp_ptr = '0; bus.resp_last = 0;
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, clock.
    task automatic step(input bit av, input int aid, input int alen,
                        input bit rv, input bit rr, input int rptr, input bit rlast);
        bit granted;
        int gptr;
        bit freed;
        bus.alloc_valid = av; bus.alloc_id = IDW'(aid); bus.alloc_len = LENW'(alen);
        bus.resp_valid = rv; bus.resp_ready = rr; bus.resp_ptr = PW'(rptr); bus.resp_last = rlast;
        #1;
        check_outputs("cyc");
        granted = av && (m_cnt() < DEPTH);
        gptr    = m_first_free();
        freed   = 0;
        if (rv && rr) begin
            if (!m_occ[rptr]) begin
                m_err_free = 1;
            end else begin
                if ((rlast && m_beat[rptr] != m_len[rptr]) || (!rlast && m_beat[rptr] == m_len[rptr]))
                    m_err_len = 1;
                m_beat[rptr]++;
                freed = rlast;
            end
        end
        if (av || rv)
            $display("txn t=%0t alloc=%0d grant=%0d ptr=%0d id=%0d len=%0d | resp=%0d ptr=%0d last=%0d free=%0d | cnt=%0d",
                     $time, av, granted, gptr, aid, alen, rv && rr, rptr, rlast, freed, m_cnt());
        if (granted) begin
            m_occ[gptr] = 1; m_id[gptr] = aid; m_len[gptr] = alen; m_beat[gptr] = 0;
        end
        if (freed) m_occ[rptr] = 0;
        @(posedge clk);
        #1;
    endtask

    // Reset asserted between edges; its effect must be visible before the next edge.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        model_reset();
        check_eq("rst_async_cnt",   bus.ost_cnt, 0);
        check_eq("rst_async_ready", bus.alloc_ready, 1);
        check_eq("rst_async_efree", bus.err_free, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int occ_list[$];
        int rp;
        bit rl;
        idle_inputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state
        check_eq("reset_ready", bus.alloc_ready, 1);
        check_eq("reset_aptr",  bus.alloc_ptr, 0);
        check_eq("reset_cnt",   bus.ost_cnt, 0);
        check_eq("reset_empty", bus.ost_empty, 1);
        check_eq("reset_full",  bus.ost_full, 0);
        check_eq("reset_sid",   bus.slot_id, 0);
        check_eq("reset_elen",  bus.err_len, 0);

        // Fill all slots back to back
        for (int i = 0; i < DEPTH; i++) begin
            check_eq("fill_aptr", bus.alloc_ptr, i);
            step(1, $urandom_range(0, 15), 0, 0, 0, 0, 0);
        end
        check_eq("fill_full",  bus.ost_full, 1);
        check_eq("fill_ready", bus.alloc_ready, 0);
        check_eq("fill_cnt",   bus.ost_cnt, DEPTH);
        check_eq("fill_aptr0", bus.alloc_ptr, 0);

        // Alloc while full together with last beat on slot 5
        step(1, 9, 0, 1, 1, 5, 1);
        check_eq("simul_cnt",  bus.ost_cnt, DEPTH - 1);
        check_eq("simul_aptr", bus.alloc_ptr, 5);
        check_eq("simul_ready", bus.alloc_ready, 1);

        // Reset in the middle of traffic
        do_reset();
        check_outputs("post_rst");

        // Hole reuse
        for (int i = 0; i < 4; i++) step(1, i + 2, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 1, 1);
        check_eq("hole_cnt3", bus.ost_cnt, 3);
        check_eq("hole_aptr", bus.alloc_ptr, 1);
        step(1, 11, 0, 0, 0, 0, 0);
        check_eq("hole_cnt4", bus.ost_cnt, 4);
        check_eq("hole_next", bus.alloc_ptr, 4);

        // Response to an empty slot
        step(0, 0, 0, 1, 1, 7, 1);
        check_eq("efree_set", bus.err_free, 1);
        check_eq("efree_cnt", bus.ost_cnt, 4);
        step(0, 0, 0, 0, 0, 0, 0);
        check_eq("efree_sticky", bus.err_free, 1);

        // Burst of len 3 ends early on beat 2
        step(1, 6, 3, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 4, 0);
        step(0, 0, 0, 1, 0, 4, 1);
        step(0, 0, 0, 1, 1, 4, 0);
        check_eq("elen_clean", bus.err_len, 0);
        step(0, 0, 0, 1, 1, 4, 1);
        check_eq("elen_early", bus.err_len, LEN_CHK ? 1 : 0);
        check_eq("elen_cnt",   bus.ost_cnt, 4);

        // Random traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n == 250) do_reset();
            occ_list.delete();
            for (int i = 0; i < DEPTH; i++) if (m_occ[i]) occ_list.push_back(i);
            if (occ_list.size() > 0 && $urandom_range(0, 9) < 8)
                rp = occ_list[$urandom_range(0, occ_list.size() - 1)];
            else
                rp = $urandom_range(0, DEPTH - 1);
            if (m_occ[rp] && $urandom_range(0, 9) < 8)
                rl = (m_beat[rp] == m_len[rp]);
            else
                rl = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), rp, rl);
        end
        check_outputs("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d expected=%0d", 1, 0);
        $fatal(1, "simulation time limit reached");
    end
endmodule

// File: doc/easyaxi_ost_alloc.md
EASYAXI_OST_ALLOC -- requirements
Module: easyaxi_ost_alloc

Interface
REQ-001 SHALL have parameter OST_DEPTH, default 16, number of outstanding-transaction slots (power of two, >=2).
REQ-002 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, AXI burst length field width (beats-1).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port alloc_valid  input  1  master requests a slot for a new address beat.
REQ-007 SHALL have port alloc_ready  output  1  a free slot exists.
REQ-008 SHALL have port alloc_id  input  ID_WIDTH  ID of requesting transaction.
REQ-009 SHALL have port alloc_len  input  LEN_WIDTH  burst length (beats-1).
REQ-010 SHALL have port alloc_ptr  output  clog2(OST_DEPTH)  slot granted; feeds the per-ID order tracker req_ptr.
REQ-011 SHALL have port resp_valid  input  1  response beat valid.
REQ-012 SHALL have port resp_ready  input  1  response beat accepted.
REQ-013 SHALL have port resp_ptr  input  clog2(OST_DEPTH)  slot of response beat, from order tracker.
REQ-014 SHALL have port resp_last  input  1  final beat of burst.
REQ-015 SHALL have port slot_id  output  ID_WIDTH  stored ID of slot resp_ptr (combinational read).
REQ-016 SHALL have port ost_cnt  output  clog2(OST_DEPTH)+1  occupied slot count.
REQ-017 SHALL have ports ost_full, ost_empty  output  1 each  ost_cnt==OST_DEPTH / ost_cnt==0.
REQ-018 SHALL have port err_free  output  1  sticky: response to an unoccupied slot.
REQ-019 SHALL have port err_len  output  1  sticky: beat count mismatch (macro-dependent).

Function
REQ-020 SHALL hold per-slot registers: valid bit, ID, len, beat counter (LEN_WIDTH+1 bits).
REQ-021 SHALL drive alloc_ready = ~ost_full, independent of alloc_valid.
REQ-022 SHALL drive alloc_ptr = lowest-index slot with valid==0 in registered bitmap; 0 when full.
REQ-023 SHALL on alloc_valid&alloc_ready set valid, store alloc_id/alloc_len, clear beat counter of slot alloc_ptr at next edge.
REQ-024 SHALL on resp_valid&resp_ready to a valid slot increment its beat counter; if resp_last clear its valid bit.
REQ-025 SHALL treat alloc and last-beat free in the same cycle independently: ost_cnt unchanged, freed slot allocatable only from next cycle.
REQ-026 SHALL ignore response handshake to a slot with valid==0 (no state change) and set err_free.
REQ-027 SHALL update ost_cnt by +1 alloc, -1 free, 0 both; never wrap.
REQ-028 SHALL produce all outputs from registers or combinational reads of registers; zero-cycle alloc_ptr/alloc_ready latency, one-cycle state update.

Reset
REQ-029 SHALL on rst clear all valid bits, counters, ost_cnt, err_free, err_len immediately (asynchronous).
REQ-030 SHALL after reset drive alloc_ready=1, alloc_ptr=0, ost_empty=1, ost_full=0, slot_id=0, errors=0.
REQ-031 SHALL discard any in-flight transactions when rst asserts mid-operation; no partial slot state survives.

Configuration
REQ-032 SHALL compile length checking only when macro EASYAXI_OST_ALLOC_LEN_CHK_EN is defined.
REQ-033 SHALL with the macro set err_len when resp_last arrives with beat counter != stored len, or a non-last beat arrives with counter == stored len.
REQ-034 SHALL without the macro omit len and beat-counter storage and tie err_len to 0.

Verification
REQ-035 SHALL verify reset: after rst release, alloc_ready=1, alloc_ptr=0, ost_cnt=0, ost_empty=1.
REQ-036 SHALL verify fill: 16 back-to-back allocs -> alloc_ptr 0..15 in order, then ost_full=1, alloc_ready=0, ost_cnt=16.
REQ-037 SHALL verify hole reuse: allocate 0..3, free slot 1 (resp_last) -> next alloc_ptr=1, ost_cnt=3 then 4.
REQ-038 SHALL verify simultaneous: with slots 0..15 full, alloc_valid and last beat on slot 5 same cycle -> alloc not granted, ost_cnt=15, next cycle alloc_ptr=5.
REQ-039 SHALL verify err_free: resp handshake with resp_ptr=7 while slot 7 empty -> err_free=1 sticky, ost_cnt unchanged.
REQ-040 SHALL verify length check (macro on): alloc len=3, resp_last on beat 2 -> err_len=1; macro off -> err_len=0.
